stack_controller: RTL and testbench
===================================

# stack_controller

Sequencer for all stack traffic in the 8-bit Harvard pipeline. It accepts one stack operation at a time from execute: PUSH, POP, CALL, RET, INT or RTI. It drives the data-memory port byte by byte, and produces the `update_enable`/`new_sp` pair consumed by the stack pointer register. Results go back to the pipeline: popped data, return PC and restored flags.

## Interface
- `STACK_LIMIT`, 8'h80: lowest data-memory address the stack may occupy; the stack grows down from 8'hFF.
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset (asserted when 0)
- `op_valid`  in  1  operation request
- `op_code`  in  3  000 PUSH, 001 POP, 010 CALL, 011 RET, 100 INT, 101 RTI, 110/111 illegal
- `op_data`  in  8  register value for PUSH
- `op_pc`  in  8  return address for CALL/INT
- `op_flags`  in  4  CCR for INT
- `op_ready`  out  1  high only in IDLE; request accepted when `op_valid & op_ready`
- `sp_in`  in  8  current stack pointer value (from stack pointer register)
- `sp_update_en`  out  1  to stack pointer `update_enable`
- `sp_new`  out  8  to stack pointer `new_sp`
- `mem_addr`  out  8  data-memory address
- `mem_wdata`  out  8  write data
- `mem_we`  out  1  write strobe
- `mem_re`  out  1  read strobe; `mem_rdata` valid the following cycle
- `mem_rdata`  in  8  read data
- `pop_valid` / `pop_data`  out  1/8  POP result for writeback
- `pc_load` / `pc_value`  out  1/8  RET/RTI PC redirect
- `flags_load` / `flags_value`  out  1/4  RTI CCR restore
- `op_done`  out  1  one-cycle pulse in the last cycle of an accepted operation
- `stack_err`  out  1  one-cycle pulse on rejected operation

## Operation
- Stack is full-descending: SP addresses the next free byte.
  - Push: write mem[SP], then SP-1.
  - Pop: SP+1, then read mem[SP+1].
- On acceptance (cycle 0):
  - latch op_code, op_data, op_pc, op_flags;
  - latch `sp_in` into working SP `wsp`;
  - `sp_in` is ignored thereafter.
- States: IDLE, W1, W2, R1, R2, RWAIT, ERR.
- PUSH/CALL, from IDLE to W1, then IDLE:
  - mem_we=1, addr=wsp, wdata=op_data (PUSH) or op_pc (CALL);
  - sp_update_en=1, sp_new=wsp-1, op_done=1.
- INT:
  - W1: write op_pc at wsp, sp_new=wsp-1.
  - W2: write {4'b0,op_flags} at wsp-1, sp_new=wsp-2, op_done.
- POP/RET:
  - R1: mem_re=1, addr=wsp+1, sp_new=wsp+1.
  - RWAIT: POP asserts pop_valid, pop_data=mem_rdata; RET asserts pc_load, pc_value=mem_rdata. op_done in the same cycle.
- RTI:
  - R1: read wsp+1 (flags), sp_new=wsp+1.
  - R2: read wsp+2 (PC), sp_new=wsp+2, flags_load=1, flags_value=mem_rdata[3:0].
  - RWAIT: pc_load, pc_value=mem_rdata, op_done.
- Bounds check at acceptance (9-bit arithmetic, no wrap):
  - Push-type needing n bytes (1 for PUSH/CALL, 2 for INT) is legal only if wsp-(n-1) ≥ STACK_LIMIT.
  - Pop-type needing n bytes (1 for POP/RET, 2 for RTI) is legal only if wsp+n ≤ 8'hFF.
- Illegal opcode or bounds violation goes to ERR for one cycle:
  - stack_err=1; no memory access, no sp update, no pop/pc/flags load, op_done=0.
  - Then IDLE.
- All strobes (mem_we, mem_re, sp_update_en, pop_valid, pc_load, flags_load, op_done, stack_err) are 0 except as listed.
- mem_addr/mem_wdata/sp_new/pop_data/pc_value/flags_value hold their last value when not strobed.

## Timing
- Reset (reset=0 at clock edge):
  - state IDLE, all strobes 0, data outputs 8'h00/4'h0, wsp=8'hFF;
  - op_ready=1 in the first cycle after reset release.
- Reset mid-operation aborts immediately: no further writes or SP updates; already-issued updates are not undone.
- Latency from acceptance edge:
  - PUSH/CALL: 1 cycle.
  - INT: 2.
  - POP/RET: 2.
  - RTI: 3.
  - Errors: 1.
- op_ready=0 in every non-IDLE cycle. A new op may be accepted in the cycle after op_done/stack_err; back-to-back throughput is (latency+1) cycles per op.
- op_valid while op_ready=0 is ignored; the requester holds it.

## Test plan
- Reset, then PUSH data 8'hA5 with sp_in=FF → next cycle mem_we=1, addr=FF, wdata=A5, sp_update_en=1, sp_new=FE, op_done=1.
- INT with pc=8'h3C, flags=4'hB, sp_in=FE → W1 writes 3C@FE, sp_new=FD; W2 writes 0B@FD, sp_new=FC, op_done.
- RTI with sp_in=FC, memory FD=0B, FE=3C → flags_load with 4'hB in cycle 2, pc_load with 8'h3C in cycle 3, sp_new FD then FE.
- POP with sp_in=FF → stack_err pulse; no mem_re, no sp_update_en. PUSH with sp_in=STACK_LIMIT → legal. INT with sp_in=STACK_LIMIT → stack_err.
- op_code=3'b111 → stack_err. op_valid held during a busy RTI is not accepted until IDLE.
- reset=0 during INT W1 → no W2 write, all strobes 0 next cycle, op_ready=1 after release.

Source files
------------

// File: rtl/stack_controller_if.sv
// Request/handshake bundle between the execute stage and the stack sequencer.
// The execute stage drives the request and the sequencer drives op_ready.
interface stack_controller_if;
  logic       op_valid;
  logic [2:0] op_code;
  logic [7:0] op_data;
  logic [7:0] op_pc;
  logic [3:0] op_flags;
  logic       op_ready;

  modport master (output op_valid, op_code, op_data, op_pc, op_flags, input op_ready);
  modport slave  (input op_valid, op_code, op_data, op_pc, op_flags, output op_ready);
endinterface

// File: rtl/stack_controller.sv
// Stack traffic sequencer: PUSH/POP/CALL/RET/INT/RTI over a byte-wide data-memory port,
// full-descending stack from 8'hFF down to STACK_LIMIT, with SP update and writeback results.
module stack_controller #(
  parameter logic [7:0] STACK_LIMIT = 8'h80
) (
  input  logic                     clk,
  input  logic                     reset,
  stack_controller_if.slave        op,
  input  logic [7:0]               sp_in,
  output logic                     sp_update_en,
  output logic [7:0]               sp_new,
  output logic [7:0]               mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [7:0]               mem_rdata,
  output logic                     pop_valid,
  output logic [7:0]               pop_data,
  output logic                     pc_load,
  output logic [7:0]               pc_value,
  output logic                     flags_load,
  output logic [3:0]               flags_value,
  output logic                     op_done,
  output logic                     stack_err
);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_INT  = 3'd4;
  localparam logic [2:0] OP_RTI  = 3'd5;

  localparam logic [8:0] LIMIT9 = {1'b0, STACK_LIMIT};
  localparam logic [8:0] TOP9   = 9'h0FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_W1    = 3'd1,
    ST_W2    = 3'd2,
    ST_R1    = 3'd3,
    ST_R2    = 3'd4,
    ST_RWAIT = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [2:0] code_r, code_nxt_s;
  logic [3:0] flags_r, flags_nxt_s;
  logic [7:0] wsp_r, wsp_nxt_s;

  logic       op_ready_r;
  logic       we_r, we_s, re_r, re_s, upd_r, upd_s;
  logic       pop_r, pop_s, pcl_r, pcl_s, fl_r, fl_s, done_r, done_s, err_r, err_s;
  logic [7:0] addr_r, addr_s, wdata_r, wdata_s, spn_r, spn_s;
  logic [7:0] pop_hold_r, pc_hold_r;
  logic [3:0] flags_hold_r;

  logic [8:0] sp9_s;
  assign sp9_s = {1'b0, sp_in};

  // Next state plus the strobes and addresses for the cycle that state will occupy
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    flags_nxt_s = flags_r;
    wsp_nxt_s   = wsp_r;
    we_s   = 1'b0;
    re_s   = 1'b0;
    upd_s  = 1'b0;
    pop_s  = 1'b0;
    pcl_s  = 1'b0;
    fl_s   = 1'b0;
    done_s = 1'b0;
    err_s  = 1'b0;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    spn_s   = spn_r;
    case (state_r)
      ST_IDLE: begin
        if (op.op_valid) begin
          code_nxt_s  = op.op_code;
          flags_nxt_s = op.op_flags;
          wsp_nxt_s   = sp_in;
          case (op.op_code)
            OP_PUSH, OP_CALL: begin
              if (sp9_s >= LIMIT9) begin
                state_nxt_s = ST_W1;
                we_s    = 1'b1;
                addr_s  = sp_in;
                wdata_s = (op.op_code == OP_CALL) ? op.op_pc : op.op_data;
                upd_s   = 1'b1;
                spn_s   = sp_in - 8'd1;
                done_s  = 1'b1;
              end else begin
                state_nxt_s = ST_ERR;
                err_s       = 1'b1;
              end
            end
            OP_INT: begin
              // Two bytes: the lower one lands at sp_in-1, so sp_in itself must clear the limit by one
              if (sp9_s >= LIMIT9 + 9'd1) begin
                state_nxt_s = ST_W1;
                we_s    = 1'b1;
                addr_s  = sp_in;
                wdata_s = op.op_pc;
                upd_s   = 1'b1;
                spn_s   = sp_in - 8'd1;
              end else begin
                state_nxt_s = ST_ERR;
                err_s       = 1'b1;
              end
            end
            OP_POP, OP_RET, OP_RTI: begin
              if (sp9_s + ((op.op_code == OP_RTI) ? 9'd2 : 9'd1) <= TOP9) begin
                state_nxt_s = ST_R1;
                re_s   = 1'b1;
                addr_s = sp_in + 8'd1;
                upd_s  = 1'b1;
                spn_s  = sp_in + 8'd1;
              end else begin
                state_nxt_s = ST_ERR;
                err_s       = 1'b1;
              end
            end
            default: begin
              state_nxt_s = ST_ERR;
              err_s       = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_W1: begin
        if (code_r == OP_INT) begin
          state_nxt_s = ST_W2;
          we_s    = 1'b1;
          addr_s  = wsp_r - 8'd1;
          wdata_s = {4'b0000, flags_r};
          upd_s   = 1'b1;
          spn_s   = wsp_r - 8'd2;
          done_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_R1: begin
        if (code_r == OP_RTI) begin
          state_nxt_s = ST_R2;
          re_s   = 1'b1;
          addr_s = wsp_r + 8'd2;
          upd_s  = 1'b1;
          spn_s  = wsp_r + 8'd2;
          fl_s   = 1'b1;
        end else begin
          state_nxt_s = ST_RWAIT;
          pop_s  = (code_r == OP_POP);
          pcl_s  = (code_r == OP_RET);
          done_s = 1'b1;
        end
      end
      ST_R2: begin
        state_nxt_s = ST_RWAIT;
        pcl_s  = 1'b1;
        done_s = 1'b1;
      end
      ST_W2, ST_RWAIT, ST_ERR: state_nxt_s = ST_IDLE;
      default:                 state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched operation and registered port strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      code_r     <= 3'd0;
      flags_r    <= 4'h0;
      wsp_r      <= 8'hFF;
      op_ready_r <= 1'b1;
      we_r   <= 1'b0;
      re_r   <= 1'b0;
      upd_r  <= 1'b0;
      pop_r  <= 1'b0;
      pcl_r  <= 1'b0;
      fl_r   <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
      spn_r   <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      code_r     <= code_nxt_s;
      flags_r    <= flags_nxt_s;
      wsp_r      <= wsp_nxt_s;
      op_ready_r <= (state_nxt_s == ST_IDLE);
      we_r   <= we_s;
      re_r   <= re_s;
      upd_r  <= upd_s;
      pop_r  <= pop_s;
      pcl_r  <= pcl_s;
      fl_r   <= fl_s;
      done_r <= done_s;
      err_r  <= err_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      spn_r   <= spn_s;
    end
  end

  // Read results arrive on mem_rdata in the strobe cycle itself; keep them afterwards
  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_hold_r   <= 8'h00;
      pc_hold_r    <= 8'h00;
      flags_hold_r <= 4'h0;
    end else begin
      pop_hold_r   <= pop_r ? mem_rdata : pop_hold_r;
      pc_hold_r    <= pcl_r ? mem_rdata : pc_hold_r;
      flags_hold_r <= fl_r ? mem_rdata[3:0] : flags_hold_r;
    end
  end

  assign op.op_ready   = op_ready_r;
  assign mem_we        = we_r;
  assign mem_re        = re_r;
  assign mem_addr      = addr_r;
  assign mem_wdata     = wdata_r;
  assign sp_update_en  = upd_r;
  assign sp_new        = spn_r;
  assign pop_valid     = pop_r;
  assign pop_data      = pop_r ? mem_rdata : pop_hold_r;
  assign pc_load       = pcl_r;
  assign pc_value      = pcl_r ? mem_rdata : pc_hold_r;
  assign flags_load    = fl_r;
  assign flags_value   = fl_r ? mem_rdata[3:0] : flags_hold_r;
  assign op_done       = done_r;
  assign stack_err     = err_r;

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller: small data-memory model, hand-computed expectations.
module tb_stack_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sp_in;
  logic       sp_update_en;
  logic [7:0] sp_new, mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, mem_re;
  logic       pop_valid, pc_load, flags_load, op_done, stack_err;
  logic [7:0] pop_data, pc_value;
  logic [3:0] flags_value;

  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  stack_controller_if op_bus ();

  stack_controller #(.STACK_LIMIT(8'h80)) dut (
    .clk(clk), .reset(reset), .op(op_bus.slave), .sp_in(sp_in),
    .sp_update_en(sp_update_en), .sp_new(sp_new),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .pop_valid(pop_valid), .pop_data(pop_data), .pc_load(pc_load), .pc_value(pc_value),
    .flags_load(flags_load), .flags_value(flags_value),
    .op_done(op_done), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data valid the cycle after mem_re
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present a request at a falling edge; it is taken on the next rising edge
  task automatic issue(input logic [2:0] code, input logic [7:0] data, input logic [7:0] pc,
                       input logic [3:0] flags, input logic [7:0] sp);
    op_bus.op_valid = 1'b1;
    op_bus.op_code  = code;
    op_bus.op_data  = data;
    op_bus.op_pc    = pc;
    op_bus.op_flags = flags;
    sp_in           = sp;
    @(posedge clk);
    #1 op_bus.op_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    reset = 1'b0;
    op_bus.op_valid = 1'b0;
    op_bus.op_code  = 3'd0;
    op_bus.op_data  = 8'h00;
    op_bus.op_pc    = 8'h00;
    op_bus.op_flags = 4'h0;
    sp_in = 8'hFF;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", op_bus.op_ready, 1);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_upd", sp_update_en, 0);
    check_eq("rst_spnew", sp_new, 8'h00);
    check_eq("rst_pop", pop_data, 8'h00);
    check_eq("rst_err", stack_err, 0);

    // PUSH A5 at FF
    issue(3'd0, 8'hA5, 8'h00, 4'h0, 8'hFF);
    check_eq("push_we", mem_we, 1);
    check_eq("push_addr", mem_addr, 8'hFF);
    check_eq("push_wdata", mem_wdata, 8'hA5);
    check_eq("push_upd", sp_update_en, 1);
    check_eq("push_spnew", sp_new, 8'hFE);
    check_eq("push_done", op_done, 1);
    check_eq("push_busy", op_bus.op_ready, 0);
    @(negedge clk);
    check_eq("push_idle_we", mem_we, 0);
    check_eq("push_idle_ready", op_bus.op_ready, 1);
    check_eq("push_spnew_hold", sp_new, 8'hFE);

    // INT pc 3C flags B at FE
    issue(3'd4, 8'h00, 8'h3C, 4'hB, 8'hFE);
    check_eq("int_w1_we", mem_we, 1);
    check_eq("int_w1_addr", mem_addr, 8'hFE);
    check_eq("int_w1_wdata", mem_wdata, 8'h3C);
    check_eq("int_w1_spnew", sp_new, 8'hFD);
    check_eq("int_w1_done", op_done, 0);
    @(negedge clk);
    check_eq("int_w2_we", mem_we, 1);
    check_eq("int_w2_addr", mem_addr, 8'hFD);
    check_eq("int_w2_wdata", mem_wdata, 8'h0B);
    check_eq("int_w2_spnew", sp_new, 8'hFC);
    check_eq("int_w2_done", op_done, 1);
    @(negedge clk);
    check_eq("int_idle_ready", op_bus.op_ready, 1);

    // RTI at FC, with a PUSH held on op_valid while busy
    op_bus.op_valid = 1'b1;
    op_bus.op_code  = 3'd5;
    sp_in           = 8'hFC;
    @(posedge clk);
    #1;
    op_bus.op_code = 3'd0;
    op_bus.op_data = 8'h5A;
    sp_in          = 8'hFE;
    @(negedge clk);
    check_eq("rti_r1_re", mem_re, 1);
    check_eq("rti_r1_addr", mem_addr, 8'hFD);
    check_eq("rti_r1_spnew", sp_new, 8'hFD);
    check_eq("rti_r1_upd", sp_update_en, 1);
    @(negedge clk);
    check_eq("rti_r2_re", mem_re, 1);
    check_eq("rti_r2_addr", mem_addr, 8'hFE);
    check_eq("rti_r2_spnew", sp_new, 8'hFE);
    check_eq("rti_r2_fload", flags_load, 1);
    check_eq("rti_r2_fval", flags_value, 4'hB);
    check_eq("rti_r2_we", mem_we, 0);
    @(negedge clk);
    check_eq("rti_rw_pcload", pc_load, 1);
    check_eq("rti_rw_pcval", pc_value, 8'h3C);
    check_eq("rti_rw_done", op_done, 1);
    check_eq("rti_rw_re", mem_re, 0);
    check_eq("rti_rw_we", mem_we, 0);
    @(negedge clk);
    check_eq("held_idle_ready", op_bus.op_ready, 1);
    check_eq("held_idle_we", mem_we, 0);
    check_eq("flags_hold", flags_value, 4'hB);
    @(posedge clk);
    #1 op_bus.op_valid = 1'b0;
    @(negedge clk);
    check_eq("held_push_we", mem_we, 1);
    check_eq("held_push_addr", mem_addr, 8'hFE);
    check_eq("held_push_wdata", mem_wdata, 8'h5A);
    @(negedge clk);

    // POP at FF underflows
    issue(3'd1, 8'h00, 8'h00, 4'h0, 8'hFF);
    check_eq("popff_err", stack_err, 1);
    check_eq("popff_re", mem_re, 0);
    check_eq("popff_upd", sp_update_en, 0);
    check_eq("popff_done", op_done, 0);
    @(negedge clk);
    check_eq("popff_err_clear", stack_err, 0);

    // PUSH at the limit is legal
    issue(3'd0, 8'h77, 8'h00, 4'h0, 8'h80);
    check_eq("push80_we", mem_we, 1);
    check_eq("push80_addr", mem_addr, 8'h80);
    check_eq("push80_spnew", sp_new, 8'h7F);
    check_eq("push80_err", stack_err, 0);
    @(negedge clk);

    // INT at the limit needs a second byte below it
    issue(3'd4, 8'h00, 8'h44, 4'h1, 8'h80);
    check_eq("int80_err", stack_err, 1);
    check_eq("int80_we", mem_we, 0);
    check_eq("int80_upd", sp_update_en, 0);
    @(negedge clk);

    // POP at FE reads FF
    issue(3'd1, 8'h00, 8'h00, 4'h0, 8'hFE);
    check_eq("pop_re", mem_re, 1);
    check_eq("pop_addr", mem_addr, 8'hFF);
    check_eq("pop_spnew", sp_new, 8'hFF);
    @(negedge clk);
    check_eq("pop_valid", pop_valid, 1);
    check_eq("pop_data", pop_data, 8'hA5);
    check_eq("pop_done", op_done, 1);
    check_eq("pop_no_pcload", pc_load, 0);
    @(negedge clk);
    check_eq("pop_valid_clear", pop_valid, 0);
    check_eq("pop_data_hold", pop_data, 8'hA5);

    // Illegal opcode
    issue(3'd7, 8'h00, 8'h00, 4'h0, 8'hF0);
    check_eq("ill_err", stack_err, 1);
    check_eq("ill_we", mem_we, 0);
    check_eq("ill_done", op_done, 0);
    @(negedge clk);

    // Reset during INT W1 suppresses W2
    issue(3'd4, 8'h00, 8'h11, 4'h2, 8'hFE);
    check_eq("rint_w1_we", mem_we, 1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rint_we", mem_we, 0);
    check_eq("rint_upd", sp_update_en, 0);
    check_eq("rint_done", op_done, 0);
    check_eq("rint_mem_fd", mem[8'hFD], 8'h0B);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rint_ready", op_bus.op_ready, 1);
    check_eq("rint_we_after", mem_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
